dmem_responder: RTL

- Data-memory responder on the far end of the MEM-stage memory interface: write port (wme, maddr, wdata) and read port (rdaddr → rdata).
- Contains a word-addressed RAM, a small memory-mapped I/O register block (LED register, free-running cycle counter, store counter) and address-error detection.
- rdata is registered with one-cycle read latency; the MEM/WB path samples it the cycle after rdaddr is presented.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_ram_1r1w.sv | 35 +++
 rtl/dmem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// address-region decode and default geometry.
package dmem_pkg;

    localparam int unsigned DEPTH_DEF     = 1024;
    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h4;
    localparam logic [3:0] OFF_STORES = 4'h8;
    localparam logic [3:0] OFF_RSVD   = 4'hC;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_ILLEGAL
    } region_e;

    // Classify a byte address. aw is log2 of the RAM depth in words.
    function automatic region_e decode_region(
        input logic [31:0] addr,
        input int unsigned aw,
        input logic [31:0] base
    );
        region_e r;
        r = REG_ILLEGAL;
        if (addr[1:0] == 2'b00) begin
            if ((addr >> (aw + 2)) == 32'd0) begin
                r = REG_RAM;
            end else if ((addr >= base) && ((addr - base) < 32'd16)) begin
                r = REG_MMIO;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram_1r1w.sv
// Single-clock 1R1W word RAM: registered read, write-first bypass when the
// read and write hit the same word in the same cycle.
module dmem_ram_1r1w #(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    // NOTE: the array has no reset; clearing it would force flops instead of a RAM macro.
    logic [31:0] mem [DEPTH];

    // Array write
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment to avoid ordering races.
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to the read word wins
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, MMIO block (LED, cycle counter, store
// counter) and address-error detection. Read data has one cycle of latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int unsigned LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rdaddr,
    input  logic             wme,
    input  logic [31:0]      maddr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led_out,
    output logic             addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    region_e          rd_region;
    region_e          wr_region;
    logic [3:0]       rd_off;
    logic [3:0]       wr_off;
    logic             wr_legal;
    logic             ram_we;
    logic             led_we;
    logic [31:0]      mmio_rd_next;
    logic [31:0]      ram_rdata;

    logic [LED_W-1:0] led_q;
    logic [31:0]      cyc_cnt;
    logic [31:0]      st_cnt;
    logic [31:0]      mmio_q;
    logic             rd_ram_q;

    assign rd_region = decode_region(rdaddr, AW, MMIO_BASE);
    assign wr_region = decode_region(maddr, AW, MMIO_BASE);

    // Window offset; only meaningful when the region is MMIO
    assign rd_off = rdaddr[3:0] - MMIO_BASE[3:0];
    assign wr_off = maddr[3:0] - MMIO_BASE[3:0];

    assign wr_legal = wme && (wr_region != REG_ILLEGAL);
    // A write landing on the edge where reset is asserted is dropped
    assign ram_we   = wme && (wr_region == REG_RAM) && !rst;
    assign led_we   = wr_legal && (wr_region == REG_MMIO) && (wr_off == OFF_LED);

    dmem_ram_1r1w #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (maddr[AW+1:2]),
        .wdata (wdata),
        .raddr (rdaddr[AW+1:2]),
        .rdata (ram_rdata)
    );

    // MMIO read value for this cycle's rdaddr; zero for RAM and illegal reads
    always_comb begin
        // NOTE: default assignment first so no path leaves the value held (no latch).
        mmio_rd_next = 32'h0;
        if (rd_region == REG_MMIO) begin
            case (rd_off)
                OFF_LED: begin
                    // Same-cycle LED write is visible to the read (write-first)
                    if (led_we) begin
                        mmio_rd_next = 32'(wdata[LED_W-1:0]);
                    end else begin
                        mmio_rd_next = 32'(led_q);
                    end
                end
                OFF_CYCLE:  mmio_rd_next = cyc_cnt;
                OFF_STORES: mmio_rd_next = st_cnt;
                OFF_RSVD:   mmio_rd_next = 32'h0;
                default:    mmio_rd_next = 32'h0;
            endcase
        end
    end

    // Counters, LED register, error pulse and the registered read selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= '0;
            cyc_cnt  <= 32'h0;
            st_cnt   <= 32'h0;
            addr_err <= 1'b0;
            mmio_q   <= 32'h0;
            rd_ram_q <= 1'b0;
        end else begin
            cyc_cnt  <= cyc_cnt + 32'd1;
            if (wr_legal) begin
                st_cnt <= st_cnt + 32'd1;
            end
            if (led_we) begin
                led_q <= wdata[LED_W-1:0];
            end
            addr_err <= (wme && (wr_region == REG_ILLEGAL)) || (rd_region == REG_ILLEGAL);
            mmio_q   <= mmio_rd_next;
            rd_ram_q <= (rd_region == REG_RAM);
        end
    end

    // rd_ram_q and mmio_q both clear on reset, so rdata reads 0 immediately
    assign rdata   = rd_ram_q ? ram_rdata : mmio_q;
    assign led_out = led_q;

endmodule
